// File: rtl/sdcmd_resp.sv
// SD CMD-line card responder: receives 48-bit host commands, hands them to user logic, sends R1-style replies.
// Optional macro SDCMD_RESP_CRC_CHECK_EN enables CRC7/end-bit checking of received frames.
module sdcmd_resp #(
    parameter int NCR     = 2,
    parameter int RESP_TO = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sdclk,
    inout  wire         sdcmd,
    output logic        busy,
    output logic        cmd_valid,
    output logic [5:0]  cmd_idx,
    output logic [31:0] cmd_arg,
    output logic        crc_err,
    output logic        timeout,
    input  logic        resp_valid,
    input  logic        resp_none,
    input  logic [5:0]  resp_cmd,
    input  logic [31:0] resp_arg
);

`ifdef SDCMD_RESP_CRC_CHECK_EN
    localparam bit CRC_CHK = 1'b1;
`else
    localparam bit CRC_CHK = 1'b0;
`endif
    localparam int TW = $clog2(RESP_TO + 1);

    typedef enum logic [2:0] {IDLE, RECV, WAIT_USR, GAP, SEND} state_t;

    state_t         state_q, state_d;
    logic [2:0]     sclk_q;
    logic [1:0]     scmd_q;
    logic [5:0]     cnt_q, cnt_d;
    logic [45:0]    sr_q, sr_d;
    logic [6:0]     crc_q, crc_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic [47:0]    txsr_q, txsr_d;
    logic           oe_q, oe_d;
    logic [5:0]     cmd_idx_q, cmd_idx_d;
    logic [31:0]    cmd_arg_q, cmd_arg_d;
    logic           cmd_valid_q, cmd_valid_d;
    logic           crc_err_q, crc_err_d;
    logic           timeout_q, timeout_d;

    logic           rise, fall, bit_in, frame_ok;
    logic [46:0]    frame;

    function automatic logic [6:0] crc7_next(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    function automatic logic [6:0] crc7_40(input logic [39:0] d);
        logic [6:0] c;
        c = '0;
        for (int i = 39; i >= 0; i--) c = crc7_next(c, d[i]);
        return c;
    endfunction

    assign rise   = sclk_q[1] & ~sclk_q[2];
    assign fall   = ~sclk_q[1] & sclk_q[2];
    assign bit_in = scmd_q[1];
    // Direction bit through end bit, including the bit arriving on this rise.
    assign frame    = {sr_q, bit_in};
    assign frame_ok = frame[46] && (!CRC_CHK || (frame[7:1] == crc_q && frame[0]));

    assign sdcmd     = oe_q ? txsr_q[47] : 1'bz;
    assign busy      = (state_q != IDLE);
    assign cmd_valid = cmd_valid_q;
    assign cmd_idx   = cmd_idx_q;
    assign cmd_arg   = cmd_arg_q;
    assign crc_err   = crc_err_q;
    assign timeout   = timeout_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        crc_d       = crc_q;
        tmo_d       = tmo_q;
        txsr_d      = txsr_q;
        oe_d        = oe_q;
        cmd_idx_d   = cmd_idx_q;
        cmd_arg_d   = cmd_arg_q;
        cmd_valid_d = 1'b0;
        crc_err_d   = 1'b0;
        timeout_d   = 1'b0;
        case (state_q)
            IDLE: if (rise && !bit_in) begin
                state_d = RECV;
                cnt_d   = 6'd46;
                crc_d   = '0;
            end
            RECV: if (rise) begin
                sr_d = {sr_q[44:0], bit_in};
                if (cnt_q >= 6'd8) crc_d = crc7_next(crc_q, bit_in);
                if (cnt_q == 6'd0) begin
                    if (frame_ok) begin
                        cmd_idx_d   = frame[45:40];
                        cmd_arg_d   = frame[39:8];
                        cmd_valid_d = 1'b1;
                        tmo_d       = '0;
                        state_d     = WAIT_USR;
                    end else begin
                        crc_err_d = CRC_CHK;
                        state_d   = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            WAIT_USR: begin
                if (resp_valid) begin
                    txsr_d  = {2'b00, resp_cmd, resp_arg,
                               crc7_40({2'b00, resp_cmd, resp_arg}), 1'b1};
                    cnt_d   = '0;
                    state_d = GAP;
                end else if (resp_none) begin
                    state_d = IDLE;
                end else if (rise) begin
                    // A new start bit from the host pre-empts the pending reply.
                    if (!bit_in) begin
                        state_d = RECV;
                        cnt_d   = 6'd46;
                        crc_d   = '0;
                    end else if (tmo_q == TW'(RESP_TO - 1)) begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end
            GAP: if (fall) begin
                if (cnt_q == 6'(NCR - 1)) state_d = SEND;
                else                      cnt_d   = cnt_q + 6'd1;
            end
            SEND: if (fall) begin
                if (!oe_q) begin
                    oe_d  = 1'b1;
                    cnt_d = 6'd47;
                end else if (cnt_q == 6'd0) begin
                    oe_d    = 1'b0;
                    state_d = IDLE;
                end else begin
                    txsr_d = {txsr_q[46:0], 1'b0};
                    cnt_d  = cnt_q - 6'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sclk_q      <= '0;
            scmd_q      <= 2'b11;
            cnt_q       <= '0;
            sr_q        <= '0;
            crc_q       <= '0;
            tmo_q       <= '0;
            txsr_q      <= '0;
            oe_q        <= 1'b0;
            cmd_idx_q   <= '0;
            cmd_arg_q   <= '0;
            cmd_valid_q <= 1'b0;
            crc_err_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_q      <= {sclk_q[1:0], sdclk};
            scmd_q      <= {scmd_q[0], sdcmd};
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            crc_q       <= crc_d;
            tmo_q       <= tmo_d;
            txsr_q      <= txsr_d;
            oe_q        <= oe_d;
            cmd_idx_q   <= cmd_idx_d;
            cmd_arg_q   <= cmd_arg_d;
            cmd_valid_q <= cmd_valid_d;
            crc_err_q   <= crc_err_d;
            timeout_q   <= timeout_d;
        end
    end

endmodule

// File: tb/tb_sdcmd_resp.sv
// Bench for sdcmd_resp: host model on sdclk/sdcmd, reactive user model, CRC7 reference by polynomial division.
module tb_sdcmd_resp;

`ifdef SDCMD_RESP_CRC_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam int NCR     = 2;
    localparam int RESP_TO = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sdclk = 1'b0;
    wire         sdcmd;
    logic        busy, cmd_valid, crc_err, timeout;
    logic [5:0]  cmd_idx;
    logic [31:0] cmd_arg;
    logic        resp_valid = 1'b0;
    logic        resp_none = 1'b0;
    logic [5:0]  resp_cmd = '0;
    logic [31:0] resp_arg = '0;

    logic        host_oe = 1'b0;
    logic        host_bit = 1'b1;
    int          user_mode = 0;
    int          rise_cnt = 0, end_rise = 0, tmo_rise = 0;
    int          nv = 0, ne = 0, nt = 0, ndrv = 0;
    logic [5:0]  last_idx = '0;
    logic [31:0] last_arg = '0;
    int          n_chk = 0, n_fail = 0;

    pullup (sdcmd);
    assign sdcmd = host_oe ? host_bit : 1'bz;

    sdcmd_resp #(.NCR(NCR), .RESP_TO(RESP_TO)) dut (
        .clk(clk), .rst_n(rst_n), .sdclk(sdclk), .sdcmd(sdcmd), .busy(busy),
        .cmd_valid(cmd_valid), .cmd_idx(cmd_idx), .cmd_arg(cmd_arg),
        .crc_err(crc_err), .timeout(timeout), .resp_valid(resp_valid),
        .resp_none(resp_none), .resp_cmd(resp_cmd), .resp_arg(resp_arg)
    );

    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    // Remainder of data*x^7 divided by x^7+x^3+1.
    function automatic logic [6:0] ref_crc(input logic [39:0] d);
        logic [46:0] r;
        r = {d, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        return r[6:0];
    endfunction

    function automatic logic [47:0] ref_frame(input logic dir, input logic [5:0] c, input logic [31:0] a);
        return {1'b0, dir, c, a, ref_crc({1'b0, dir, c, a}), 1'b1};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pulse counters and detection of the card pulling the line low.
    always @(negedge clk) begin
        if (cmd_valid) begin nv++; last_idx = cmd_idx; last_arg = cmd_arg; end
        if (crc_err) ne++;
        if (timeout) begin nt++; tmo_rise = rise_cnt; end
        if (!host_oe && sdcmd !== 1'b1) ndrv++;
    end

    // User logic: reacts on the clk after cmd_valid (0 silent, 1 none, 2 reply, 3 both).
    always @(negedge clk) begin
        resp_valid = 1'b0;
        resp_none  = 1'b0;
        if (cmd_valid) begin
            resp_none  = (user_mode == 1 || user_mode == 3);
            resp_valid = (user_mode == 2 || user_mode == 3);
        end
    end

    task automatic sd_tick(input logic oe, input logic b, output logic s);
        @(negedge clk);
        host_oe = oe; host_bit = b;
        repeat (7) @(negedge clk);
        sdclk = 1'b1; rise_cnt++;
        repeat (4) @(negedge clk);
        s = sdcmd;
        repeat (4) @(negedge clk);
        sdclk = 1'b0;
    endtask

    task automatic send_cmd(input logic [47:0] f);
        logic s;
        repeat (2) sd_tick(1'b1, 1'b1, s);
        for (int i = 47; i >= 0; i--) sd_tick(1'b1, f[i], s);
        end_rise = rise_cnt;
    endtask

    task automatic idle_ticks(input int n);
        logic s;
        for (int i = 0; i < n; i++) sd_tick(1'b0, 1'b1, s);
    endtask

    task automatic get_resp(output logic [47:0] r, output logic ok, output int lat);
        logic s;
        ok = 1'b0; r = '0; lat = 0;
        for (int k = 0; k < 100 && !ok; k++) begin
            sd_tick(1'b0, 1'b1, s);
            if (!s) begin ok = 1'b1; lat = rise_cnt - end_rise; end
        end
        if (ok) for (int i = 46; i >= 0; i--) begin sd_tick(1'b0, 1'b1, s); r[i] = s; end
        idle_ticks(2);
    endtask

    typedef struct {
        logic [5:0]  cmd;
        logic [31:0] arg;
        logic [6:0]  crc;
        logic        dir;
        int          mode;
        logic [5:0]  rcmd;
        logic [31:0] rarg;
        logic        exp_valid;
        logic        exp_err;
        logic        exp_resp;
    } vec_t;

    task automatic run_vec(input string tag, input vec_t v);
        int v0, e0, t0, d0, lat;
        logic [47:0] r;
        logic ok;
        v0 = nv; e0 = ne; t0 = nt; d0 = ndrv;
        user_mode = v.mode; resp_cmd = v.rcmd; resp_arg = v.rarg;
        send_cmd({1'b0, v.dir, v.cmd, v.arg, v.crc, 1'b1});
        if (v.exp_resp) begin
            get_resp(r, ok, lat);
            chk({tag, "_resp_seen"}, 64'(ok), 64'(1));
            chk({tag, "_resp_frame"}, 64'(r), 64'(ref_frame(1'b0, v.rcmd, v.rarg)));
            chk({tag, "_resp_latency"}, 64'(lat), 64'(NCR + 1));
        end else begin
            idle_ticks(6);
            chk({tag, "_no_drive"}, 64'(ndrv - d0), 64'(0));
        end
        chk({tag, "_cmd_valid"}, 64'(nv - v0), 64'(v.exp_valid));
        chk({tag, "_crc_err"}, 64'(ne - e0), 64'(v.exp_err));
        chk({tag, "_timeout"}, 64'(nt - t0), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        if (v.exp_valid) begin
            chk({tag, "_cmd_idx"}, 64'(last_idx), 64'(v.cmd));
            chk({tag, "_cmd_arg"}, 64'(last_arg), 64'(v.arg));
        end
    endtask

    initial begin
        vec_t tbl[5];
        vec_t v;
        int v0, t0, d0;
        logic s, ok;

        tbl[0] = '{6'd0,  32'h0,      7'h4A, 1'b1, 1, 6'd0,  32'h0,   1'b1, 1'b0, 1'b0};
        tbl[1] = '{6'd8,  32'h1AA,    7'h43, 1'b1, 2, 6'd8,  32'h1AA, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{6'd17, 32'h0,      7'h2B, 1'b1, 1, 6'd0,  32'h0,   !CHK, CHK,  1'b0};
        tbl[3] = '{6'd55, 32'h0, ref_crc({2'b01, 6'd55, 32'h0}), 1'b1, 3, 6'd55, 32'h120, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{6'd17, 32'h0, ref_crc({2'b00, 6'd17, 32'h0}), 1'b0, 1, 6'd0, 32'h0, 1'b0, CHK, 1'b0};

        repeat (5) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_cmd_valid", 64'(cmd_valid), 64'(0));
        chk("reset_crc_err", 64'(crc_err), 64'(0));
        chk("reset_timeout", 64'(timeout), 64'(0));
        chk("reset_cmd_idx_arg", 64'({cmd_idx, cmd_arg}), 64'(0));
        chk("reset_sdcmd_released", 64'(sdcmd), 64'(1));
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

        for (int i = 0; i < 6; i++) begin
            v.cmd  = 6'($urandom_range(0, 63));
            v.arg  = $urandom;
            v.dir  = 1'b1;
            v.crc  = ref_crc({2'b01, v.cmd, v.arg});
            v.mode = $urandom_range(1, 2);
            v.rcmd = 6'($urandom_range(0, 63));
            v.rarg = $urandom;
            v.exp_valid = 1'b1;
            v.exp_err   = 1'b0;
            v.exp_resp  = (v.mode == 2);
            run_vec($sformatf("rand%0d", i), v);
        end

        // No user reply: timeout exactly RESP_TO rises after the end bit.
        v0 = nv; t0 = nt; d0 = ndrv;
        user_mode = 0;
        send_cmd(ref_frame(1'b1, 6'd8, 32'h1AA));
        for (int k = 0; k < 80 && nt == t0; k++) idle_ticks(1);
        idle_ticks(2);
        chk("tmo_cmd_valid", 64'(nv - v0), 64'(1));
        chk("tmo_pulse", 64'(nt - t0), 64'(1));
        chk("tmo_rise_count", 64'(tmo_rise - end_rise), 64'(RESP_TO));
        chk("tmo_busy", 64'(busy), 64'(0));
        chk("tmo_no_drive", 64'(ndrv - d0), 64'(0));

        // New host command while awaiting the user aborts the wait.
        v0 = nv; t0 = nt;
        user_mode = 0;
        send_cmd(ref_frame(1'b1, 6'd8, 32'h1AA));
        idle_ticks(3);
        user_mode = 1;
        send_cmd(ref_frame(1'b1, 6'd2, 32'hCAFE0001));
        idle_ticks(4);
        chk("abort_cmd_valid", 64'(nv - v0), 64'(2));
        chk("abort_idx_arg", 64'({last_idx, last_arg}), 64'({6'd2, 32'hCAFE0001}));
        chk("abort_timeout", 64'(nt - t0), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));

        // Reset while the card drives bit 20 of its response (an arg zero).
        user_mode = 2; resp_cmd = 6'd8; resp_arg = 32'h1AA;
        send_cmd(ref_frame(1'b1, 6'd8, 32'h1AA));
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            sd_tick(1'b0, 1'b1, s);
            ok = !s;
        end
        chk("rst_resp_started", 64'(ok), 64'(1));
        for (int i = 1; i < 20; i++) sd_tick(1'b0, 1'b1, s);
        @(negedge clk);
        repeat (7) @(negedge clk);
        sdclk = 1'b1; rise_cnt++;
        repeat (4) @(negedge clk);
        chk("rst_bit20_driven_low", 64'(sdcmd), 64'(0));
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_sdcmd_released", 64'(sdcmd), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_cmd_idx", 64'(cmd_idx), 64'(0));
        sdclk = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        v.cmd = 6'd0; v.arg = 32'h0; v.crc = 7'h4A; v.dir = 1'b1; v.mode = 1;
        v.rcmd = 6'd0; v.rarg = 32'h0; v.exp_valid = 1'b1; v.exp_err = 1'b0; v.exp_resp = 1'b0;
        run_vec("post_rst_cmd0", v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
